// File: rtl/trig_seq_gen.sv
// Synchronised trigger router: each accepted TRIGIN pulse goes to the next enabled channel
// (round-robin) or to all enabled channels (broadcast). Optional counter: TRIG_SEQ_CNT_EN.
module trig_seq_gen #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNTW        = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           TRIGIN,
    input  logic [NCH-1:0] ENMASK,
    input  logic           MODE,
    input  logic           SEQ_RST,
    output logic [NCH-1:0] TRIGOUT,
    output logic [NCH-1:0] CHSEL,
    output logic           BUSY,
    output logic           LEDOUT
`ifdef TRIG_SEQ_CNT_EN
    ,
    output logic [CNTW-1:0] TRIGCNT
`endif
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {StIdle, StPulse} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   trig_d1_q, trig_d1_d;
    logic                   armed_q, armed_d;
    logic [NCH-1:0]         trigout_q, trigout_d;
    logic                   mode_q, mode_d;
    logic [PW-1:0]          rt_idx_q, rt_idx_d;
    logic [PW-1:0]          ptr_q, ptr_d;

    logic                   trig_s;
    logic                   rise;
    logic                   fall;
    logic                   accept;
    logic [NCH-1:0]         route_rr;
    logic [NCH-1:0]         route_w;
    logic [PW-1:0]          rr_idx;

    assign trig_s = sync_q[SYNC_STAGES-1];
    assign rise   = armed_q & trig_s & ~trig_d1_q;
    assign fall   = ~trig_s & trig_d1_q;
    assign accept = (state_q == StIdle) & rise;

    // Circular search for the first enabled channel at or after the pointer.
    always_comb begin
        int unsigned base;
        int unsigned j;
        logic        found;
        route_rr = '0;
        rr_idx   = '0;
        found    = 1'b0;
        base     = SEQ_RST ? 0 : int'(ptr_q);
        for (int unsigned k = 0; k < NCH; k++) begin
            j = (base + k) % NCH;
            if (!found && ENMASK[j]) begin
                found       = 1'b1;
                route_rr[j] = 1'b1;
                rr_idx      = PW'(j);
            end
        end
    end

    assign route_w = MODE ? ENMASK : route_rr;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], TRIGIN};
        fill_d    = {fill_q[SYNC_STAGES-2:0], 1'b1};
        trig_d1_d = trig_s;
        // Only arm once the chain holds real samples, so a level held through reset is ignored.
        armed_d   = armed_q | (fill_q[SYNC_STAGES-1] & ~trig_s);
        state_d   = state_q;
        trigout_d = trigout_q;
        mode_d    = mode_q;
        rt_idx_d  = rt_idx_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d   = StPulse;
                    trigout_d = route_w;
                    mode_d    = MODE;
                    rt_idx_d  = rr_idx;
                end
            end
            StPulse: begin
                if (fall) begin
                    state_d   = StIdle;
                    trigout_d = '0;
                    if (!mode_q && (|trigout_q)) begin
                        ptr_d = (rt_idx_q == PW'(NCH - 1)) ? '0 : rt_idx_q + PW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (SEQ_RST) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            sync_q    <= '0;
            fill_q    <= '0;
            trig_d1_q <= 1'b0;
            armed_q   <= 1'b0;
            trigout_q <= '0;
            mode_q    <= 1'b0;
            rt_idx_q  <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            fill_q    <= fill_d;
            trig_d1_q <= trig_d1_d;
            armed_q   <= armed_d;
            trigout_q <= trigout_d;
            mode_q    <= mode_d;
            rt_idx_q  <= rt_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        CHSEL        = '0;
        CHSEL[ptr_q] = 1'b1;
    end

    assign TRIGOUT = trigout_q;
    assign BUSY    = (state_q == StPulse);
    assign LEDOUT  = ~|trigout_q;

`ifdef TRIG_SEQ_CNT_EN
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (SEQ_RST) begin
            cnt_d = '0;
        end else if (accept && (|route_w) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TRIGCNT = cnt_q;
`endif

endmodule

// File: tb/tb_trig_seq_gen.sv
// Scoreboard bench for trig_seq_gen (NCH=4, SYNC_STAGES=2, CNTW=2); counter checks need
// TRIG_SEQ_CNT_EN.
module tb_trig_seq_gen;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TRIGIN = 1'b0;
    logic [3:0] ENMASK = 4'b1111;
    logic       MODE = 1'b0;
    logic       SEQ_RST = 1'b0;
    logic [3:0] TRIGOUT;
    logic [3:0] CHSEL;
    logic       BUSY;
    logic       LEDOUT;
`ifdef TRIG_SEQ_CNT_EN
    logic [1:0] TRIGCNT;
`endif

    trig_seq_gen #(
        .NCH(4),
        .SYNC_STAGES(2),
        .CNTW(2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .TRIGIN(TRIGIN),
        .ENMASK(ENMASK),
        .MODE(MODE),
        .SEQ_RST(SEQ_RST),
        .TRIGOUT(TRIGOUT),
        .CHSEL(CHSEL),
        .BUSY(BUSY),
        .LEDOUT(LEDOUT)
`ifdef TRIG_SEQ_CNT_EN
        ,
        .TRIGCNT(TRIGCNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] tout;
        logic [3:0] chsel;
        int         width;  // 0: pulse aborted by reset, skip end-of-pulse checks
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    logic mon_active = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop an expectation on each BUSY rise, finish checks on the fall.
    initial begin
        exp_t cur;
        logic prev_busy;
        int   hi;
        prev_busy = 1'b0;
        hi = 0;
        cur = '{tout: 4'b0, chsel: 4'b0, width: 0};
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_busy  = 1'b0;
                mon_active = 1'b0;
            end else begin
                if (BUSY && !prev_busy) begin
                    if (q.size() == 0) begin
                        check("unexpected_pulse", {28'b0, TRIGOUT}, 32'hFFFF_FFFF);
                    end else begin
                        cur = q.pop_front();
                        check("trigout", {28'b0, TRIGOUT}, {28'b0, cur.tout});
                        check("latency", cyc - rise_cyc, 3);
                        hi = 1;
                        mon_active = 1'b1;
                    end
                end else if (BUSY) begin
                    hi++;
                end else if (prev_busy && mon_active) begin
                    if (cur.width != 0) begin
                        check("width", hi, cur.width);
                        check("chsel_after", {28'b0, CHSEL}, {28'b0, cur.chsel});
                    end
                    mon_active = 1'b0;
                end
                prev_busy = BUSY;
            end
        end
    end

    task automatic push(input logic [3:0] tout, input logic [3:0] chsel, input int width);
        q.push_back('{tout: tout, chsel: chsel, width: width});
    endtask

    task automatic start_pulse();
        @(posedge CLK);
        #1 TRIGIN = 1'b1;
        rise_cyc = cyc;
    endtask

    task automatic pulse(input int width, input int gap);
        start_pulse();
        repeat (width) @(posedge CLK);
        #1 TRIGIN = 1'b0;
        repeat (gap) @(posedge CLK);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1 RST = 1'b1;
        TRIGIN = 1'b0;
        SEQ_RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (5) @(posedge CLK);
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_trigout", {28'b0, TRIGOUT}, 32'h0);
        check("rst_chsel", {28'b0, CHSEL}, 32'h1);
        check("rst_busy", {31'b0, BUSY}, 32'h0);
        check("rst_ledout", {31'b0, LEDOUT}, 32'h1);
        RST = 1'b0;
        repeat (5) @(posedge CLK);

        // Round-robin over all channels
        push(4'b0001, 4'b0010, 10);
        push(4'b0010, 4'b0100, 10);
        push(4'b0100, 4'b1000, 10);
        push(4'b1000, 4'b0001, 10);
        push(4'b0001, 4'b0010, 10);
        for (int i = 0; i < 5; i++) pulse(10, 6);

        // Round-robin skipping disabled channels
        do_reset();
        ENMASK = 4'b1010;
        push(4'b0010, 4'b0100, 10);
        push(4'b1000, 4'b0001, 10);
        push(4'b0010, 4'b0100, 10);
        for (int i = 0; i < 3; i++) pulse(10, 6);

        // Broadcast; mid-pulse ENMASK/MODE changes are ignored
        do_reset();
        MODE = 1'b1;
        ENMASK = 4'b0110;
        push(4'b0110, 4'b0001, 10);
        start_pulse();
        repeat (5) @(posedge CLK);
        #1 ENMASK = 4'b1111;
        MODE = 1'b0;
        check("ledout_active", {31'b0, LEDOUT}, 32'h0);
        repeat (2) @(posedge CLK);
        #1 check("mid_change_trigout", {28'b0, TRIGOUT}, 32'h6);
        repeat (3) @(posedge CLK);
        #1 TRIGIN = 1'b0;
        MODE = 1'b1;
        ENMASK = 4'b0110;
        repeat (6) @(posedge CLK);
        push(4'b0110, 4'b0001, 10);
        pulse(10, 6);
        ENMASK = 4'b0000;
        push(4'b0000, 4'b0001, 10);
        start_pulse();
        repeat (5) @(posedge CLK);
        #1 check("empty_mask_busy", {31'b0, BUSY}, 32'h1);
        check("empty_mask_ledout", {31'b0, LEDOUT}, 32'h1);
        repeat (5) @(posedge CLK);
        #1 TRIGIN = 1'b0;
        repeat (6) @(posedge CLK);

        // TRIGIN held high through reset release: first pulse ignored
        MODE = 1'b0;
        ENMASK = 4'b1111;
        @(posedge CLK);
        #1 RST = 1'b1;
        TRIGIN = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (8) @(posedge CLK);
        #1 check("held_high_busy", {31'b0, BUSY}, 32'h0);
        TRIGIN = 1'b0;
        repeat (4) @(posedge CLK);
        push(4'b0001, 4'b0010, 10);
        pulse(10, 6);

        // SEQ_RST coincident with the detected fall while on ch2
        do_reset();
        push(4'b0001, 4'b0010, 10);
        push(4'b0010, 4'b0100, 10);
        for (int i = 0; i < 2; i++) pulse(10, 6);
        push(4'b0100, 4'b0001, 10);
        start_pulse();
        repeat (10) @(posedge CLK);
        #1 TRIGIN = 1'b0;
        repeat (2) @(posedge CLK);
        #1 SEQ_RST = 1'b1;
        @(posedge CLK);
        #1 SEQ_RST = 1'b0;
        check("seq_rst_chsel", {28'b0, CHSEL}, 32'h1);
        repeat (5) @(posedge CLK);
        push(4'b0001, 4'b0010, 10);
        pulse(10, 6);

        // Accepted-trigger counter saturation
        do_reset();
        push(4'b0001, 4'b0010, 10);
        push(4'b0010, 4'b0100, 10);
        push(4'b0100, 4'b1000, 10);
        push(4'b1000, 4'b0001, 10);
        push(4'b0001, 4'b0010, 10);
        for (int i = 0; i < 5; i++) begin
            pulse(10, 6);
`ifdef TRIG_SEQ_CNT_EN
            check("trigcnt", {30'b0, TRIGCNT}, (i < 3) ? i + 1 : 3);
`endif
        end
        @(posedge CLK);
        #1 SEQ_RST = 1'b1;
        @(posedge CLK);
        #1 SEQ_RST = 1'b0;
        check("seq_rst_chsel2", {28'b0, CHSEL}, 32'h1);
`ifdef TRIG_SEQ_CNT_EN
        check("trigcnt_clear", {30'b0, TRIGCNT}, 32'h0);
`endif

        // RST mid-pulse drops TRIGOUT at once and clears the pointer
        do_reset();
        push(4'b0001, 4'b0010, 10);
        pulse(10, 6);
        push(4'b0010, 4'b0000, 0);
        start_pulse();
        repeat (6) @(posedge CLK);
        #1 check("pre_rst_trigout", {28'b0, TRIGOUT}, 32'h2);
        RST = 1'b1;
        #1;
        check("rst_mid_trigout", {28'b0, TRIGOUT}, 32'h0);
        check("rst_mid_busy", {31'b0, BUSY}, 32'h0);
        check("rst_mid_chsel", {28'b0, CHSEL}, 32'h1);
        TRIGIN = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (5) @(posedge CLK);

        guard = 0;
        while ((q.size() != 0 || mon_active) && guard < 200) begin
            @(posedge CLK);
            guard++;
        end
        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
